rgmii_rx_deframer: RTL and testbench

- Receive-side counterpart of the RGMII transmit DDR path.
- Takes per-edge nibbles and RX_CTL samples, already captured by the input DDR primitives into the `clk` domain, and assembles them into bytes.
- Strips preamble and SFD, checks length and CRC-32, and emits a byte stream with `m_last` and `m_err` markers to the MAC RX logic.
- The stream has no backpressure, because the PHY cannot be stalled.

---
 rtl/rgmii_rx_deframer_if.sv | 15 +
 rtl/rgmii_rx_deframer.sv | 154 +++++++++++++++
 tb/tb_rgmii_rx_deframer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_rx_deframer_if.sv
// Receive byte stream from the RGMII deframer to the MAC RX logic.
//   m_data  : received byte; FCS bytes included
//   m_valid : m_data valid this cycle; no backpressure
//   m_last  : final byte of the frame; qualified by m_valid
//   m_err   : frame bad; meaningful only with m_last
// Modports: master drives the stream (deframer), slave consumes it.
interface rgmii_rx_deframer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;

  modport master (output m_data, m_valid, m_last, m_err);
  modport slave  (input  m_data, m_valid, m_last, m_err);
endinterface

// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer. Assembles DDR-captured nibbles into bytes, strips
// preamble/SFD, checks length and CRC-32, and streams bytes with last/err
// markers. One byte of lookahead is held so the final byte can carry m_last.
// Ports:
//   clk, rst            : RX clock, asynchronous active-low reset
//   rxd_rise/rxd_fall   : low/high nibble of the byte
//   rx_ctl_rise/_fall   : RX_DV and RX_DV^RX_ER samples
//   rx (master)         : m_data/m_valid/m_last/m_err stream
//   frame_ok/frame_bad  : single-cycle pulses alongside a good/bad m_last
module rgmii_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 rxd_rise,
  input  logic [3:0]                 rxd_fall,
  input  logic                       rx_ctl_rise,
  input  logic                       rx_ctl_fall,
  rgmii_rx_deframer_if.master        rx,
  output logic                       frame_ok,
  output logic                       frame_bad
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_C       = 11'(MIN_LEN);
  localparam logic [10:0] MAX_P1      = 11'(MAX_LEN + 1);

  typedef enum logic [2:0] {SYNC, IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic [7:0]  s_byte;
  logic        s_dv;
  logic        s_er;
  logic        primed;     // input register holds a real sample, not its reset value
  logic [31:0] crc;
  logic [10:0] cnt;
  logic [7:0]  hold;
  logic        hold_full;
  logic        err_flag;

  logic [10:0] cnt_nxt;
  logic        bad;

  // Reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    cnt_nxt = (cnt == MAX_P1) ? cnt : cnt + 11'd1;
    bad     = (crc != CRC_RESIDUE) || (cnt < MIN_C) || err_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYNC;
      s_byte     <= '0;
      s_dv       <= 1'b0;
      s_er       <= 1'b0;
      primed     <= 1'b0;
      crc        <= CRC_INIT;
      cnt        <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      err_flag   <= 1'b0;
      rx.m_data  <= '0;
      rx.m_valid <= 1'b0;
      rx.m_last  <= 1'b0;
      rx.m_err   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      s_byte <= {rxd_fall, rxd_rise};
      s_dv   <= rx_ctl_rise;
      s_er   <= rx_ctl_rise ^ rx_ctl_fall;
      primed <= 1'b1;

      rx.m_valid <= 1'b0;
      rx.m_last  <= 1'b0;
      rx.m_err   <= 1'b0;
      frame_ok   <= 1'b0;
      frame_bad  <= 1'b0;

      case (state)
        // Until the first real dv=0 sample we may be inside someone's frame.
        SYNC: if (primed && !s_dv) state <= IDLE;

        // dv=0 samples (including carrier extension) keep us here.
        IDLE: if (s_dv) state <= (s_byte == 8'h55) ? PRE : DROP;

        PRE: begin
          if (!s_dv)                 state <= IDLE;
          else if (s_byte == 8'hD5) begin
            state     <= DATA;
            crc       <= CRC_INIT;
            cnt       <= '0;
            err_flag  <= 1'b0;
            hold_full <= 1'b0;
          end
          else if (s_byte != 8'h55)  state <= DROP;
        end

        DATA: begin
          if (!s_dv) begin
            // End of frame: release the held byte as last. An SFD with no
            // data leaves the hold empty and produces nothing.
            state     <= IDLE;
            hold_full <= 1'b0;
            if (hold_full) begin
              rx.m_data  <= hold;
              rx.m_valid <= 1'b1;
              rx.m_last  <= 1'b1;
              rx.m_err   <= bad;
              frame_ok   <= !bad;
              frame_bad  <= bad;
            end
          end else if (cnt_nxt == MAX_P1) begin
            // Oversize: close the frame on the held byte, discard the rest.
            state      <= DROP;
            cnt        <= cnt_nxt;
            hold_full  <= 1'b0;
            rx.m_data  <= hold;
            rx.m_valid <= 1'b1;
            rx.m_last  <= 1'b1;
            rx.m_err   <= 1'b1;
            frame_bad  <= 1'b1;
          end else begin
            crc       <= crc_byte(crc, s_byte);
            cnt       <= cnt_nxt;
            if (s_er) err_flag <= 1'b1;
            if (hold_full) begin
              rx.m_data  <= hold;
              rx.m_valid <= 1'b1;
            end
            hold      <= s_byte;
            hold_full <= 1'b1;
          end
        end

        DROP: if (!s_dv) state <= IDLE;

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
module tb_rgmii_rx_deframer;
  logic       clk;
  logic       rst;
  logic [3:0] rxd_rise, rxd_fall;
  logic       rx_ctl_rise, rx_ctl_fall;
  logic       frame_ok, frame_bad;

  rgmii_rx_deframer_if m_if ();

  rgmii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd_rise    (rxd_rise),
    .rxd_fall    (rxd_fall),
    .rx_ctl_rise (rx_ctl_rise),
    .rx_ctl_fall (rx_ctl_fall),
    .rx          (m_if),
    .frame_ok    (frame_ok),
    .frame_bad   (frame_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected beats: {data, last, err}
  logic [9:0] exp_q[$];
  logic [7:0] frm[$];

  // Scoreboard consumer, run once per cycle at the falling edge.
  task automatic sample();
    logic [9:0] e;
    if (m_if.m_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h last=%b err=%b, required no beat",
                 m_if.m_data, m_if.m_last, m_if.m_err);
      end else begin
        e = exp_q.pop_front();
        if ({m_if.m_data, m_if.m_last, m_if.m_err} !== e) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b err=%b, required data=%h last=%b err=%b",
                   m_if.m_data, m_if.m_last, m_if.m_err, e[9:2], e[1], e[0]);
        end
        checks++;
        if (frame_ok !== (e[1] & ~e[0])) begin
          errors++;
          $display("FAIL frame_ok: got %b, required %b", frame_ok, e[1] & ~e[0]);
        end
        checks++;
        if (frame_bad !== (e[1] & e[0])) begin
          errors++;
          $display("FAIL frame_bad: got %b, required %b", frame_bad, e[1] & e[0]);
        end
      end
    end else if (m_if.m_valid !== 1'b0 || frame_ok !== 1'b0 || frame_bad !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_outputs: got valid=%b ok=%b bad=%b, required 0 0 0",
               m_if.m_valid, frame_ok, frame_bad);
    end
  endtask

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    rxd_rise    = b[3:0];
    rxd_fall    = b[7:4];
    rx_ctl_rise = dv;
    rx_ctl_fall = dv ^ er;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
  endtask

  // Builds payload of (total-4) random bytes plus FCS into frm.
  task automatic build(input int total, input bit flip);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total - 4; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    if (flip) c[0] = ~c[0];
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  // Full frame: expected beats pushed as the frame is driven.
  task automatic send_frame(input int total, input bit flip, input int er_idx);
    bit bad;
    int nexp;
    build(total, flip);
    bad  = flip || (er_idx >= 0) || (total < 64) || (total > 1518);
    nexp = (total > 1518) ? 1518 : total;
    for (int i = 0; i < nexp; i++)
      exp_q.push_back({frm[i], (i == nexp - 1), (i == nexp - 1) && bad});
    preamble(7);
    for (int i = 0; i < total; i++) drive(frm[i], 1'b1, (i == er_idx));
    idle(3);
  endtask

  task automatic check_drained(input string name);
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d beats outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxd_rise = '0; rxd_fall = '0; rx_ctl_rise = 1'b0; rx_ctl_fall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_if.m_valid !== 1'b0 || m_if.m_last !== 1'b0 || m_if.m_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b last=%b err=%b, required 0 0 0",
               m_if.m_valid, m_if.m_last, m_if.m_err);
    end
    checks++;
    if (m_if.m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h, required 00", m_if.m_data);
    end
    checks++;
    if (frame_ok !== 1'b0 || frame_bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got ok=%b bad=%b, required 0 0", frame_ok, frame_bad);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_good_frame();
    send_frame(64, 1'b0, -1);
    check_drained("good_frame");
  endtask

  task automatic test_bad_fcs();
    send_frame(64, 1'b1, -1);
    check_drained("bad_fcs");
  endtask

  task automatic test_rx_er();
    send_frame(64, 1'b0, 20);
    check_drained("rx_er");
  endtask

  task automatic test_bad_preamble();
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hAB, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    idle(3);
    // SFD with no data behind it
    preamble(7);
    idle(3);
    // carrier extension while idle
    for (int i = 0; i < 4; i++) drive(8'h0F, 1'b0, 1'b1);
    idle(2);
    send_frame(64, 1'b0, -1);
    check_drained("bad_preamble");
  endtask

  task automatic test_reset_mid_frame();
    build(64, 1'b0);
    // Bytes 0..27 are out before reset hits while byte 29 is registered.
    for (int i = 0; i < 28; i++) exp_q.push_back({frm[i], 1'b0, 1'b0});
    preamble(7);
    for (int i = 0; i < 30; i++) drive(frm[i], 1'b1, 1'b0);
    @(negedge clk);
    sample();
    #1;
    rst = 1'b0;
    for (int i = 30; i < 33; i++) drive(frm[i], 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 33; i < 64; i++) drive(frm[i], 1'b1, 1'b0);
    idle(3);
    check_drained("reset_mid");
    send_frame(64, 1'b0, -1);
    check_drained("after_reset");
  endtask

  task automatic test_lengths();
    send_frame(40, 1'b0, -1);
    check_drained("len40");
    send_frame(1519, 1'b0, -1);
    check_drained("len1519");
    send_frame(1518, 1'b0, -1);
    check_drained("len1518");
  endtask

  task automatic test_back_to_back();
    build(64, 1'b0);
    send_frame(70, 1'b0, -1);
    send_frame(64, 1'b1, -1);
    send_frame(100, 1'b0, -1);
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rx_er();
    test_bad_preamble();
    test_reset_mid_frame();
    test_lengths();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
